// File: rtl/simplecpu_pkg.sv
// Shared constants and types for the simpleCPU front end.
// The fetch stage and its FIFO import these.
package simplecpu_pkg;

  localparam int ADDR_SIZE = 11;
  localparam int WORD_SIZE = 9;
  localparam logic [ADDR_SIZE-1:0] RESET_PC = '0;

  typedef struct packed {
    logic [WORD_SIZE-1:0] word;
    logic [ADDR_SIZE-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-to-decode channel: the instruction valid/ready handshake and the redirect request.
// The fetch stage is the master. The decoder is the slave.
interface fetch_unit_if
  import simplecpu_pkg::*;
#(
  parameter int AddrSize = ADDR_SIZE,
  parameter int WordSize = WORD_SIZE
) ();

  logic [WordSize-1:0] instr;
  logic [AddrSize-1:0] instr_pc;
  logic                instr_valid;
  logic                instr_ready;
  logic                redirect;
  logic [AddrSize-1:0] redirect_pc;

  modport master (
    output instr,
    output instr_pc,
    output instr_valid,
    input  instr_ready,
    input  redirect,
    input  redirect_pc
  );

  modport slave (
    input  instr,
    input  instr_pc,
    input  instr_valid,
    output instr_ready,
    output redirect,
    output redirect_pc
  );

endinterface

// File: rtl/fetch_fifo.sv
// Two-entry synchronous FIFO of fetched {word, pc} entries.
// It supports flush and allows a push and a pop in the same cycle even when the FIFO is full.
module fetch_fifo
  import simplecpu_pkg::*;
#(
  parameter type entry_t = fetch_entry_t
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_flush,
  input  logic       i_push,
  input  entry_t     i_din,
  input  logic       i_pop,
  output entry_t     o_dout,
  output logic [1:0] o_occ
);

  entry_t     r_mem [2];
  logic       r_rd;
  logic       r_wr;
  logic [1:0] r_occ;

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_rd  <= 1'b0;
      r_wr  <= 1'b0;
      r_occ <= 2'd0;
    end else begin
      if (i_push) r_wr <= ~r_wr;
      if (i_pop)  r_rd <= ~r_rd;
      r_occ <= r_occ + {1'b0, i_push} - {1'b0, i_pop};
    end
  end

  // When the FIFO is full, the write slot is the head being popped in this same cycle.
  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_wr] <= i_din;
  end

  assign o_dout = r_mem[r_rd];
  assign o_occ  = r_occ;

  a_no_overflow: assert property (@(posedge clk) disable iff (rst || i_flush)
    !(i_push && !i_pop && r_occ == 2'd2));

  a_no_underflow: assert property (@(posedge clk) disable iff (rst || i_flush)
    !(i_pop && r_occ == 2'd0));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage. It drives the synchronous instruction ROM and buffers the returned words.
// Each word is presented to the decoder tagged with its PC. Redirect restarts fetch at a new PC.
module fetch_unit
  import simplecpu_pkg::*;
#(
  parameter int                  AddrSize = ADDR_SIZE,
  parameter int                  WordSize = WORD_SIZE,
  parameter logic [AddrSize-1:0] ResetPc  = AddrSize'(RESET_PC)
) (
  input  logic                clk,
  input  logic                rst,
  output logic [AddrSize-1:0] rom_addr,
  output logic                rom_en,
  input  logic [WordSize-1:0] rom_do,
  fetch_unit_if.master        dec
);

  typedef struct packed {
    logic [WordSize-1:0] word;
    logic [AddrSize-1:0] pc;
  } entry_t;

  logic [AddrSize-1:0] r_fetch_pc;
  logic [AddrSize-1:0] r_inflight_pc;
  logic                r_inflight;

  logic [1:0] w_occ;
  logic [2:0] w_credit;
  logic       w_valid;
  logic       w_pop;
  logic       w_push;
  entry_t     w_din;
  entry_t     w_head;

  assign w_valid = !rst && (w_occ != 2'd0);
  assign w_pop   = w_valid && dec.instr_ready;

  // Count the buffered words plus the outstanding read, minus the word leaving this cycle.
  // Allowing a new read only while this total is below 2 keeps the FIFO from overflowing.
  assign w_credit = {1'b0, w_occ} + {2'b0, r_inflight} - {2'b0, w_pop};
  assign rom_en   = !rst && !dec.redirect && (w_credit < 3'd2);
  assign rom_addr = r_fetch_pc;

  assign w_push = r_inflight && !dec.redirect && !rst;
  assign w_din  = '{word: rom_do, pc: r_inflight_pc};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc <= ResetPc;
      r_inflight <= 1'b0;
    end else if (dec.redirect) begin
      r_fetch_pc <= dec.redirect_pc;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= rom_en;
      if (rom_en) r_fetch_pc <= r_fetch_pc + AddrSize'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rom_en) r_inflight_pc <= r_fetch_pc;
  end

  fetch_fifo #(
    .entry_t (entry_t)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_flush (dec.redirect),
    .i_push  (w_push),
    .i_din   (w_din),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_occ   (w_occ)
  );

  assign dec.instr       = w_head.word;
  assign dec.instr_pc    = w_head.pc;
  assign dec.instr_valid = w_valid;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit. A scoreboard of expected PCs is loaded whenever fetch is (re)started.
// Each accepted instruction is then popped from it and compared.
module tb_fetch_unit;
  import simplecpu_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [ADDR_SIZE-1:0] rom_addr;
  logic                 rom_en;
  logic [WORD_SIZE-1:0] rom_do;
  logic [WORD_SIZE-1:0] mem [2**ADDR_SIZE];

  fetch_unit_if dec ();

  fetch_unit dut (
    .clk      (clk),
    .rst      (rst),
    .rom_addr (rom_addr),
    .rom_en   (rom_en),
    .rom_do   (rom_do),
    .dec      (dec)
  );

  always #5 clk = ~clk;

  initial for (int i = 0; i < 2**ADDR_SIZE; i++) mem[i] = WORD_SIZE'(i % 512);

  always @(posedge clk) rom_do <= rom_en ? mem[rom_addr] : '0;

  int n_chk = 0;
  int n_err = 0;
  int n_xfer = 0;
  int b;
  int found;
  logic [ADDR_SIZE-1:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic load_seq(input logic [ADDR_SIZE-1:0] start);
    exp_q.delete();
    for (int i = 0; i < 256; i++) exp_q.push_back(start + ADDR_SIZE'(i));
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Called in the first cycle after a restart edge; returns in cycle 3 after its negedge.
  task automatic expect_restart(input string tag, input logic [ADDR_SIZE-1:0] pc);
    @(negedge clk);
    chk({tag, "_c1_en"}, rom_en, 1);
    chk({tag, "_c1_addr"}, rom_addr, pc);
    chk({tag, "_c1_vld"}, dec.instr_valid, 0);
    nxt();
    @(negedge clk);
    chk({tag, "_c2_vld"}, dec.instr_valid, 0);
    nxt();
    @(negedge clk);
    chk({tag, "_c3_vld"}, dec.instr_valid, 1);
    chk({tag, "_c3_pc"}, dec.instr_pc, pc);
  endtask

  task automatic count_window(input string tag, input int k);
    int base;
    base = n_xfer;
    repeat (k) nxt();
    chk(tag, n_xfer - base, k);
  endtask

  // Scoreboard: every accepted transfer must be the next expected PC and its ROM word.
  always @(negedge clk) begin
    if (!rst && dec.instr_valid && dec.instr_ready) begin
      n_xfer++;
      if (exp_q.size() == 0) begin
        chk("sb_underflow", exp_q.size(), 1);
      end else begin
        logic [ADDR_SIZE-1:0] p;
        p = exp_q.pop_front();
        chk("sb_pc", dec.instr_pc, p);
        chk("sb_word", dec.instr, p % 512);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    dec.instr_ready = 1'b1;
    dec.redirect = 1'b0;
    dec.redirect_pc = '0;
    repeat (3) nxt();
    @(negedge clk);
    chk("rst_vld", dec.instr_valid, 0);
    chk("rst_en", rom_en, 0);
    nxt();

    rst = 1'b0;
    load_seq(RESET_PC);
    expect_restart("boot", RESET_PC);
    nxt();

    found = 0;
    for (int i = 0; i < 10 && found == 0; i++) begin
      if (dec.instr_valid && dec.instr_pc == 4) found = 1;
      else nxt();
    end
    chk("bp_find", found, 1);
    dec.instr_ready = 1'b0;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk);
      chk("bp_vld", dec.instr_valid, 1);
      chk("bp_pc", dec.instr_pc, 4);
      chk("bp_word", dec.instr, 4);
      if (j >= 2) chk("bp_en", rom_en, 0);
      nxt();
    end
    dec.instr_ready = 1'b1;
    count_window("bp_resume", 12);

    dec.instr_ready = 1'b0;
    repeat (3) nxt();
    dec.redirect = 1'b1;
    dec.redirect_pc = 11'h100;
    @(negedge clk);
    chk("rd_full_en", rom_en, 0);
    nxt();
    dec.redirect = 1'b0;
    dec.instr_ready = 1'b1;
    load_seq(11'h100);
    expect_restart("rd_full", 11'h100);
    nxt();
    count_window("rd_full_stream", 8);

    dec.redirect = 1'b1;
    dec.redirect_pc = 11'h3AA;
    nxt();
    dec.redirect_pc = 11'd2046;
    @(negedge clk);
    chk("b2b_en", rom_en, 0);
    chk("b2b_vld", dec.instr_valid, 0);
    nxt();
    dec.redirect = 1'b0;
    load_seq(11'd2046);
    expect_restart("wrap", 11'd2046);
    nxt();
    @(negedge clk);
    chk("wrap_pc_2047", dec.instr_pc, 2047);
    nxt();
    @(negedge clk);
    chk("wrap_pc_0", dec.instr_pc, 0);
    nxt();
    @(negedge clk);
    chk("wrap_pc_1", dec.instr_pc, 1);
    nxt();

    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("mrst_vld", dec.instr_valid, 0);
    chk("mrst_en", rom_en, 0);
    nxt();
    rst = 1'b0;
    load_seq(RESET_PC);
    expect_restart("mrst", RESET_PC);
    repeat (4) nxt();

    b = n_xfer;
    dec.redirect = 1'b1;
    dec.redirect_pc = 11'h055;
    @(negedge clk);
    chk("rda_vld", dec.instr_valid, 1);
    chk("rda_en", rom_en, 0);
    nxt();
    chk("rda_accept", n_xfer - b, 1);
    dec.redirect = 1'b0;
    load_seq(11'h055);
    expect_restart("rda", 11'h055);
    nxt();
    count_window("rda_stream", 6);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
